// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU issue block and its command FIFO.
//   - OP_ADD/OP_SUB/OP_AND/OP_OR : 2-bit ALU operation codes
//   - DEFAULT_DEPTH              : default command buffer depth
//   - issue_state_e              : issue FSM state encoding
//   - cmd_width()                : width of one packed {op, a, b} command
package alu_pkg;

  localparam int DEFAULT_DEPTH = 4;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    OUT     = 2'd3
  } issue_state_e;

  // A command is packed as {op[1:0], a[WIDTH-1:0], b[WIDTH-1:0]}.
  function automatic int cmd_width(input int width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry synchronous FIFO holding packed ALU commands.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears pointers/count)
//   push, push_data : write push_data at the tail (ignored when full)
//   pop             : advance the head (ignored when empty)
//   head            : entry at the head, valid whenever count > 0
//   count           : number of stored entries, 0..DEPTH
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [2*WIDTH+1:0]           push_data,
  input  logic                         pop,
  output logic [2*WIDTH+1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CMD_W = cmd_width(WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: buffers ALU commands and sequences them one at a time through an
// external registered ALU, returning results in acceptance order.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready          : command handshake; in_a, in_b, in_op carry the command
//   alu_a, alu_b, alu_op       : registered operands/op driven to the ALU
//   alu_ena                    : one-cycle ALU capture enable per command
//   alu_ans                    : registered ALU result
//   out_valid/out_ready        : result handshake; out_data carries the result
//   dbg_state, dbg_count       : FSM state and buffer occupancy for observation
//
// Handshakes: a transfer happens at a rising edge where valid && ready. A
// source holds valid and its payload stable until that edge; ready never
// depends combinationally on valid or on the opposite side's ready.
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  input  logic [1:0]                  in_op,
  output logic [WIDTH-1:0]            alu_a,
  output logic [WIDTH-1:0]            alu_b,
  output logic [1:0]                  alu_op,
  output logic                        alu_ena,
  input  logic [WIDTH-1:0]            alu_ans,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [1:0]                  dbg_state,
  output logic [$clog2(DEPTH+1)-1:0]  dbg_count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  issue_state_e       state;
  issue_state_e       next_state;
  logic               pop;
  logic               push;
  logic [2*WIDTH+1:0] head;
  logic [CNT_W-1:0]   count;

  // in_ready comes from the registered count only.
  assign in_ready  = count < CNT_W'(DEPTH);
  assign push      = in_valid && in_ready;
  assign dbg_state = state;
  assign dbg_count = count;

  alu_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({in_op, in_a, in_b}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // OUT implies out_valid, so out_ready alone completes the result handshake.
  // Popping straight from OUT into ISSUE gives the 3-cycle result cadence.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = OUT;
      OUT: begin
        if (out_ready) begin
          if (count != '0) begin
            pop        = 1'b1;
            next_state = ISSUE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      alu_ena   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state   <= next_state;
      // Registered so alu_ena is high exactly for the cycle spent in ISSUE.
      alu_ena <= (next_state == ISSUE);
      if (pop) begin
        alu_op <= head[2*WIDTH+1:2*WIDTH];
        alu_a  <= head[2*WIDTH-1:WIDTH];
        alu_b  <= head[WIDTH-1:0];
      end
      if (state == CAPTURE) begin
        out_data  <= alu_ans;
        out_valid <= 1'b1;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
